spi_log_framer: RTL and testbench
=================================

// Module: spi_log_framer
// PURPOSE
//  Downstream of the SPI device decoder: converts synchronized SPI byte events into
//  fixed-size transaction records (cmd, 24-bit addr, payload length).
//  Buffers records in a small FIFO. Streams them byte-wise to the UART TX FIFO over
//  its ready/strobe handshake.
//  Replaces ad-hoc cmd logging in top; reports records it could not buffer.
// PARAMETERS
//  DEPTH      16     record FIFO depth; power of 2, >=2
//  SYNC_BYTE  8'hA5  first byte of every record
//  TS_SHIFT   10     timestamp = free-running clk counter >> TS_SHIFT (SPI_LOG_TS_EN only)
// PORTS
//  clk              in   1   system clock (96 MHz)
//  rst_n            in   1   synchronous reset, active low
//  log_en           in   1   capture enable
//  spi_rx_strobe    in   1   1-cycle pulse: spi_rx_data valid (already in clk domain)
//  spi_rx_cmd       in   1   qualifies strobe: byte is first of a transaction
//  spi_rx_data      in   8   received MOSI byte
//  spi_cs_n         in   1   synchronized chip select; 1 = deselected
//  uart_txd         out  8   byte to UART TX FIFO
//  uart_txd_strobe  out  1   1-cycle write pulse
//  uart_txd_ready   in   1   UART FIFO can accept a byte
//  drop_count       out  16  records lost to full FIFO; saturates at 16'hFFFF
//  busy             out  1   capture active, FIFO non-empty or serializer active
// BEHAVIOUR
//  Reset: uart_txd=0, uart_txd_strobe=0, drop_count=0, busy=0, FIFO empty, FSMs idle.
//  Reset mid-record discards all captured and queued data.
//  Capture FSM: IDLE -> ADDR (3 bytes, MSB first) -> DATA.
//   IDLE: strobe&cmd&log_en -> latch cmd; addr=0; len=0 -> ADDR.
//   ADDR: each strobe stores next addr byte; after the 3rd -> DATA.
//   DATA: each strobe increments len (16 bit, saturates at FFFF).
//   Close: spi_cs_n==1 in ADDR/DATA -> push record -> IDLE.
//    Missing addr bytes stay 00; len=0.
//   Strobe&cmd in ADDR/DATA (no deselect seen):
//    close current record and open the new one in the same cycle.
//   log_en low: IDLE holds. A record in progress is discarded, not pushed, not counted.
//   Suppression: cmd==00 and addr==000000 -> not pushed, not counted.
//  Push: when FIFO full (evaluated before a same-cycle pop), record dropped and drop_count++.
//   Push latency: record visible to serializer 1 cycle after close.
//  Record (7 bytes): SYNC, CMD, A[23:16], A[15:8], A[7:0], LEN[15:8], LEN[7:0].
//  Serializer: IDLE -> pop FIFO head -> SEND.
//   SEND: strobe only when uart_txd_ready==1 and strobe was low the previous cycle.
//    Max 1 byte per 2 clks.
//   uart_txd is valid in the strobe cycle. After the last byte -> IDLE.
//   A record is never truncated: log_en low or new pushes do not interrupt SEND.
//  busy = capture!=IDLE | FIFO non-empty | serializer!=IDLE.
// CONFIGURATION
//  SPI_LOG_TS_EN defined: free-running counter; ts = counter[TS_SHIFT+15:TS_SHIFT].
//   ts latched at the cmd strobe. Record grows to 9 bytes:
//   SYNC, TS[15:8], TS[7:0], CMD, A2, A1, A0, LEN_HI, LEN_LO.
//   FIFO word widens to 72 bits.
//  SPI_LOG_TS_EN undefined: no counter, 7-byte records, 56-bit FIFO word.
// STRUCTURE
//  Package spi_log_pkg:
//   - record byte-index constants
//   - REC_BYTES (7/9, macro-dependent)
//   - REC_W (56/72)
//   - capture and serializer state encodings
//  Sub-module spi_log_fifo:
//   - synchronous single-clock FIFO, width REC_W, DEPTH entries
//   - ports push/pop/full/empty
//   - pop-of-empty and push-to-full are ignored
//  Top of this block: capture FSM, drop counter, serializer FSM.
// TESTING
//  1. 03 01 23 45 + 4 data bytes, then cs_n=1
//     -> UART A5 03 01 23 45 00 04; drop_count=0.
//  2. 9F then cs_n=1 (no addr) -> A5 9F 00 00 00 00 00.
//  3. 03 00 00 10 + 2 bytes, then 0B 10 00 00 with no deselect
//     -> two records; 1st LEN=0002, 2nd LEN=0000 after cs_n=1.
//  4. uart_txd_ready=0; DEPTH+3 transactions
//     -> drop_count=3; on release, exactly DEPTH records, byte-exact, in order.
//  5. rst_n=0 mid-SEND, 3 bytes out -> strobe stops next cycle; no further bytes; drop_count=0.
//  6. SPI_LOG_TS_EN, TS_SHIFT=0, cmd at counter=0x1234
//     -> record A5 12 34 ...; all-zero cmd/addr transaction produces no output.

Source files
------------

// File: rtl/spi_log_pkg.sv
`default_nettype none
// ============================================================================
// spi_log_pkg : record layout, sizes and FSM encodings for spi_log_framer.
// Layout depends on SPI_LOG_TS_EN.                                   Rev 1.0
// ============================================================================
package spi_log_pkg;

`ifdef SPI_LOG_TS_EN
   localparam int REC_BYTES  = 9;
   localparam int IDX_SYNC   = 0;
   localparam int IDX_TS_HI  = 1;
   localparam int IDX_TS_LO  = 2;
   localparam int IDX_CMD    = 3;
   localparam int IDX_A2     = 4;
   localparam int IDX_A1     = 5;
   localparam int IDX_A0     = 6;
   localparam int IDX_LEN_HI = 7;
   localparam int IDX_LEN_LO = 8;
`else
   localparam int REC_BYTES  = 7;
   localparam int IDX_SYNC   = 0;
   localparam int IDX_CMD    = 1;
   localparam int IDX_A2     = 2;
   localparam int IDX_A1     = 3;
   localparam int IDX_A0     = 4;
   localparam int IDX_LEN_HI = 5;
   localparam int IDX_LEN_LO = 6;
`endif

   localparam int REC_W = REC_BYTES * 8;

   localparam logic [1:0] CAP_IDLE = 2'd0;
   localparam logic [1:0] CAP_ADDR = 2'd1;
   localparam logic [1:0] CAP_DATA = 2'd2;

   localparam logic [0:0] SER_IDLE = 1'b0;
   localparam logic [0:0] SER_SEND = 1'b1;

   // Byte 0 of a record occupies the most significant byte of the word.
   function automatic logic [REC_W-1:0] put_byte(input logic [REC_W-1:0] rec,
                                                 input int idx,
                                                 input logic [7:0] b);
      logic [REC_W-1:0] r;
      r = rec;
      r[REC_W-1-8*idx -: 8] = b;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_log_fifo.sv
`default_nettype none
// ============================================================================
// spi_log_fifo : single-clock record FIFO; push-to-full and pop-of-empty
// are ignored.                                                        Rev 1.0
// ============================================================================
module spi_log_fifo #(
   parameter int WIDTH = 56,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rdata = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop && !empty)
            rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule
`default_nettype wire

// File: rtl/spi_log_framer.sv
`default_nettype none
// ============================================================================
// spi_log_framer : SPI byte events -> buffered transaction records -> UART.
// Optional timestamp field via SPI_LOG_TS_EN.                         Rev 1.0
// ============================================================================
module spi_log_framer
   import spi_log_pkg::*;
#(
   parameter int         DEPTH     = 16,
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         TS_SHIFT  = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        log_en,
   input  logic        spi_rx_strobe,
   input  logic        spi_rx_cmd,
   input  logic [7:0]  spi_rx_data,
   input  logic        spi_cs_n,
   output logic [7:0]  uart_txd,
   output logic        uart_txd_strobe,
   input  logic        uart_txd_ready,
   output logic [15:0] drop_count,
   output logic        busy
);
   localparam logic [3:0] LAST_BYTE = 4'(REC_BYTES - 1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_SHIFT < 0) begin : g_param_check
      $error("spi_log_framer: DEPTH must be a power of 2 >= 2, TS_SHIFT >= 0");
   end

   logic [1:0]       cap_state;
   logic [7:0]       cmd;
   logic [23:0]      addr;
   logic [15:0]      len;
   logic [1:0]       addr_cnt;
   logic             cmd_strobe, data_strobe, in_rec, close_rec, push_req;
   logic             fifo_full, fifo_empty, pop;
   logic [REC_W-1:0] rec_in, fifo_head;
   logic [0:0]       ser_state;
   logic [REC_W-1:0] shreg;
   logic [3:0]       byte_idx;
   logic             strobe_q;

   assign cmd_strobe  = spi_rx_strobe & spi_rx_cmd;
   assign data_strobe = spi_rx_strobe & ~spi_rx_cmd;
   assign in_rec      = (cap_state != CAP_IDLE);
   assign close_rec   = in_rec & log_en & (spi_cs_n | cmd_strobe);
   assign push_req    = close_rec & ~((cmd == 8'h00) && (addr == 24'h000000));

`ifdef SPI_LOG_TS_EN
   logic [TS_SHIFT+15:0] ts_cnt;
   logic [15:0]          ts;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ts_cnt <= '0;
         ts     <= '0;
      end else begin
         ts_cnt <= ts_cnt + (TS_SHIFT+16)'(1);
         if (log_en && cmd_strobe)
            ts <= ts_cnt[TS_SHIFT+15:TS_SHIFT];
      end
   end
`endif

   always_comb begin
      rec_in = '0;
      rec_in = put_byte(rec_in, IDX_SYNC, SYNC_BYTE);
`ifdef SPI_LOG_TS_EN
      rec_in = put_byte(rec_in, IDX_TS_HI, ts[15:8]);
      rec_in = put_byte(rec_in, IDX_TS_LO, ts[7:0]);
`endif
      rec_in = put_byte(rec_in, IDX_CMD, cmd);
      rec_in = put_byte(rec_in, IDX_A2, addr[23:16]);
      rec_in = put_byte(rec_in, IDX_A1, addr[15:8]);
      rec_in = put_byte(rec_in, IDX_A0, addr[7:0]);
      rec_in = put_byte(rec_in, IDX_LEN_HI, len[15:8]);
      rec_in = put_byte(rec_in, IDX_LEN_LO, len[7:0]);
   end

   // A cmd strobe during a record closes it (via push_req) and opens the next.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cap_state <= CAP_IDLE;
         cmd       <= '0;
         addr      <= '0;
         len       <= '0;
         addr_cnt  <= '0;
      end else if (!log_en) begin
         cap_state <= CAP_IDLE;
      end else if (cmd_strobe) begin
         cmd       <= spi_rx_data;
         addr      <= '0;
         len       <= '0;
         addr_cnt  <= '0;
         cap_state <= CAP_ADDR;
      end else if (in_rec && spi_cs_n) begin
         cap_state <= CAP_IDLE;
      end else if (data_strobe) begin
         if (cap_state == CAP_ADDR) begin
            case (addr_cnt)
               2'd0:    addr[23:16] <= spi_rx_data;
               2'd1:    addr[15:8]  <= spi_rx_data;
               default: addr[7:0]   <= spi_rx_data;
            endcase
            addr_cnt <= addr_cnt + 2'd1;
            if (addr_cnt == 2'd2)
               cap_state <= CAP_DATA;
         end else if (cap_state == CAP_DATA && len != 16'hFFFF) begin
            len <= len + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         drop_count <= '0;
      else if (push_req && fifo_full && drop_count != 16'hFFFF)
         drop_count <= drop_count + 16'd1;
   end

   spi_log_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_req),
      .wdata (rec_in),
      .pop   (pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A record is only taken from the FIFO once the UART can accept bytes.
   assign pop             = (ser_state == SER_IDLE) & ~fifo_empty & uart_txd_ready;
   assign uart_txd_strobe = (ser_state == SER_SEND) & uart_txd_ready & ~strobe_q;
   assign uart_txd        = uart_txd_strobe ? shreg[REC_W-1 -: 8] : 8'h00;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ser_state <= SER_IDLE;
         shreg     <= '0;
         byte_idx  <= '0;
         strobe_q  <= 1'b0;
      end else begin
         strobe_q <= uart_txd_strobe;
         if (pop) begin
            shreg     <= fifo_head;
            byte_idx  <= '0;
            ser_state <= SER_SEND;
         end else if (uart_txd_strobe) begin
            shreg <= shreg << 8;
            if (byte_idx == LAST_BYTE)
               ser_state <= SER_IDLE;
            else
               byte_idx <= byte_idx + 4'd1;
         end
      end
   end

   assign busy = in_rec | ~fifo_empty | (ser_state != SER_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_log_framer.sv
`default_nettype none
// ============================================================================
// tb_spi_log_framer : directed self-checking bench for spi_log_framer. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_spi_log_framer;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst_n, log_en, spi_rx_strobe, spi_rx_cmd, spi_cs_n, uart_txd_ready;
   logic [7:0]  spi_rx_data;
   logic [7:0]  uart_txd;
   logic        uart_txd_strobe;
   logic [15:0] drop_count;
   logic        busy;

   int          tests = 0;
   int          fails = 0;
   logic [7:0]  rx_q[$];
   logic [7:0]  exp_q[$];
   int          gap_viol = 0;
   logic        prev_stb = 1'b0;

   spi_log_framer #(
      .DEPTH     (DEPTH),
      .SYNC_BYTE (8'hA5),
      .TS_SHIFT  (0)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .log_en          (log_en),
      .spi_rx_strobe   (spi_rx_strobe),
      .spi_rx_cmd      (spi_rx_cmd),
      .spi_rx_data     (spi_rx_data),
      .spi_cs_n        (spi_cs_n),
      .uart_txd        (uart_txd),
      .uart_txd_strobe (uart_txd_strobe),
      .uart_txd_ready  (uart_txd_ready),
      .drop_count      (drop_count),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (uart_txd_strobe) begin
         rx_q.push_back(uart_txd);
         if (prev_stb)
            gap_viol <= gap_viol + 1;
      end
      prev_stb <= uart_txd_strobe;
   end

`ifdef SPI_LOG_TS_EN
   logic [15:0] tb_cnt;
   logic [15:0] txn_ts;
   always @(posedge clk) tb_cnt <= rst_n ? tb_cnt + 16'd1 : 16'd0;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic spi_byte(input logic [7:0] d, input logic c);
      spi_rx_data   = d;
      spi_rx_cmd    = c;
      spi_rx_strobe = 1'b1;
`ifdef SPI_LOG_TS_EN
      if (c) txn_ts = tb_cnt;
`endif
      tick();
      spi_rx_strobe = 1'b0;
      spi_rx_cmd    = 1'b0;
      tick();
   endtask

   // Sends one transaction and, if expected, appends its record to exp_q.
   task automatic send_txn(input logic [7:0] c, input logic [23:0] a, input int n_addr,
                           input int n_data, input bit deselect, input bit expect_out);
      logic [23:0] a_exp;
      a_exp    = 24'h0;
      spi_cs_n = 1'b0;
      spi_byte(c, 1'b1);
      for (int i = 0; i < n_addr; i++) begin
         spi_byte(a[23-8*i -: 8], 1'b0);
         a_exp[23-8*i -: 8] = a[23-8*i -: 8];
      end
      for (int i = 0; i < n_data; i++)
         spi_byte(8'(8'h40 + i), 1'b0);
      if (deselect) begin
         spi_cs_n = 1'b1;
         tick();
      end
      if (expect_out) begin
         exp_q.push_back(8'hA5);
`ifdef SPI_LOG_TS_EN
         exp_q.push_back(txn_ts[15:8]);
         exp_q.push_back(txn_ts[7:0]);
`endif
         exp_q.push_back(c);
         exp_q.push_back(a_exp[23:16]);
         exp_q.push_back(a_exp[15:8]);
         exp_q.push_back(a_exp[7:0]);
         exp_q.push_back(8'(n_data >> 8));
         exp_q.push_back(8'(n_data));
      end
   endtask

   task automatic wait_bytes(input int n, input int budget, output bit ok);
      int c;
      c = 0;
      while (rx_q.size() < n && c < budget) begin
         tick();
         c++;
      end
      ok = (rx_q.size() >= n);
      idle(20);
   endtask

   task automatic clear_q();
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (uart_txd !== 8'h00) begin fails++; $display("FAIL reset_txd got %02h want 00", uart_txd); end
      tests++; if (uart_txd_strobe !== 1'b0) begin fails++; $display("FAIL reset_strobe got %b want 0", uart_txd_strobe); end
      tests++; if (drop_count !== 16'h0) begin fails++; $display("FAIL reset_drop got %04h want 0000", drop_count); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
   endtask

   task automatic test_basic();
      bit ok;
      clear_q();
      send_txn(8'h03, 24'h012345, 3, 4, 1'b1, 1'b1);
      wait_bytes(exp_q.size(), 300, ok);
      tests++; if (!ok || rx_q.size() != exp_q.size()) begin fails++; $display("FAIL basic_count got %0d want %0d", rx_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         tests++; if (rx_q[i] !== exp_q[i]) begin fails++; $display("FAIL basic_byte%0d got %02h want %02h", i, rx_q[i], exp_q[i]); end
      end
`ifndef SPI_LOG_TS_EN
      tests++; if (rx_q.size() > 6 && rx_q[6] !== 8'h04) begin fails++; $display("FAIL basic_len got %02h want 04", rx_q[6]); end
`endif
      tests++; if (drop_count !== 16'h0) begin fails++; $display("FAIL basic_drop got %04h want 0000", drop_count); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy got %b want 0", busy); end
   endtask

   task automatic test_no_addr();
      bit ok;
      clear_q();
      send_txn(8'h9F, 24'h000000, 0, 0, 1'b1, 1'b1);
      wait_bytes(exp_q.size(), 300, ok);
      tests++; if (!ok || rx_q.size() != exp_q.size()) begin fails++; $display("FAIL noaddr_count got %0d want %0d", rx_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         tests++; if (rx_q[i] !== exp_q[i]) begin fails++; $display("FAIL noaddr_byte%0d got %02h want %02h", i, rx_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      clear_q();
      send_txn(8'h03, 24'h000010, 3, 2, 1'b0, 1'b1);
      send_txn(8'h0B, 24'h100000, 3, 0, 1'b1, 1'b1);
      wait_bytes(exp_q.size(), 400, ok);
      tests++; if (!ok || rx_q.size() != exp_q.size()) begin fails++; $display("FAIL b2b_count got %0d want %0d", rx_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         tests++; if (rx_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_byte%0d got %02h want %02h", i, rx_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_suppress();
      bit ok;
      clear_q();
      send_txn(8'h00, 24'h000000, 3, 2, 1'b1, 1'b0);
      send_txn(8'h00, 24'h000001, 3, 0, 1'b1, 1'b1);
      wait_bytes(exp_q.size(), 300, ok);
      tests++; if (!ok || rx_q.size() != exp_q.size()) begin fails++; $display("FAIL suppress_count got %0d want %0d", rx_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         tests++; if (rx_q[i] !== exp_q[i]) begin fails++; $display("FAIL suppress_byte%0d got %02h want %02h", i, rx_q[i], exp_q[i]); end
      end
      tests++; if (drop_count !== 16'h0) begin fails++; $display("FAIL suppress_drop got %04h want 0000", drop_count); end
   endtask

   task automatic test_log_en();
      clear_q();
      spi_cs_n = 1'b0;
      spi_byte(8'h55, 1'b1);
      spi_byte(8'h11, 1'b0);
      log_en = 1'b0;
      tick();
      log_en = 1'b1;
      spi_cs_n = 1'b1;
      tick();
      log_en = 1'b0;
      send_txn(8'h66, 24'h123456, 3, 1, 1'b1, 1'b0);
      log_en = 1'b1;
      idle(40);
      tests++; if (rx_q.size() != 0) begin fails++; $display("FAIL logen_count got %0d want 0", rx_q.size()); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL logen_busy got %b want 0", busy); end
      tests++; if (drop_count !== 16'h0) begin fails++; $display("FAIL logen_drop got %04h want 0000", drop_count); end
   endtask

   task automatic test_overflow();
      bit ok;
      clear_q();
      uart_txd_ready = 1'b0;
      for (int i = 0; i < DEPTH + 3; i++)
         send_txn(8'(8'h10 + i), {8'h00, 8'(i), 8'hAA}, 3, i % 3, 1'b1, i < DEPTH);
      idle(5);
      tests++; if (drop_count !== 16'd3) begin fails++; $display("FAIL ovf_drop got %0d want 3", drop_count); end
      tests++; if (rx_q.size() != 0) begin fails++; $display("FAIL ovf_held got %0d want 0", rx_q.size()); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ovf_busy got %b want 1", busy); end
      uart_txd_ready = 1'b1;
      wait_bytes(exp_q.size(), 2000, ok);
      tests++; if (!ok || rx_q.size() != exp_q.size()) begin fails++; $display("FAIL ovf_count got %0d want %0d", rx_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         tests++; if (rx_q[i] !== exp_q[i]) begin fails++; $display("FAIL ovf_byte%0d got %02h want %02h", i, rx_q[i], exp_q[i]); end
      end
      tests++; if (gap_viol != 0) begin fails++; $display("FAIL strobe_gap got %0d want 0", gap_viol); end
   endtask

   task automatic test_reset_mid_send();
      int c;
      clear_q();
      send_txn(8'h21, 24'hA2B3C4, 3, 2, 1'b1, 1'b1);
      c = 0;
      while (rx_q.size() < 3 && c < 100) begin
         tick();
         c++;
      end
      tests++; if (rx_q.size() != 3) begin fails++; $display("FAIL rst_mid_pre got %0d want 3", rx_q.size()); end
      rst_n = 1'b0;
      tick();
      tests++; if (uart_txd_strobe !== 1'b0) begin fails++; $display("FAIL rst_mid_strobe got %b want 0", uart_txd_strobe); end
      tick();
      rst_n = 1'b1;
      idle(40);
      tests++; if (rx_q.size() != 3) begin fails++; $display("FAIL rst_mid_count got %0d want 3", rx_q.size()); end
      for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
         tests++; if (rx_q[i] !== exp_q[i]) begin fails++; $display("FAIL rst_mid_byte%0d got %02h want %02h", i, rx_q[i], exp_q[i]); end
      end
      tests++; if (drop_count !== 16'h0) begin fails++; $display("FAIL rst_mid_drop got %04h want 0000", drop_count); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", busy); end
   endtask

`ifdef SPI_LOG_TS_EN
   task automatic test_timestamp();
      bit ok;
      int c;
      do_reset();
      clear_q();
      c = 0;
      while (tb_cnt != 16'h1234 && c < 10000) begin
         tick();
         c++;
      end
      send_txn(8'h03, 24'h000102, 3, 0, 1'b1, 1'b1);
      wait_bytes(exp_q.size(), 300, ok);
      tests++; if (!ok || rx_q.size() != 9) begin fails++; $display("FAIL ts_count got %0d want 9", rx_q.size()); end
      tests++; if (rx_q.size() > 2 && (rx_q[1] !== 8'h12 || rx_q[2] !== 8'h34)) begin fails++; $display("FAIL ts_value got %02h%02h want 1234", rx_q[1], rx_q[2]); end
   endtask
`endif

   initial begin
      rst_n          = 1'b0;
      log_en         = 1'b1;
      spi_rx_strobe  = 1'b0;
      spi_rx_cmd     = 1'b0;
      spi_rx_data    = 8'h00;
      spi_cs_n       = 1'b1;
      uart_txd_ready = 1'b1;
      test_reset();
      test_basic();
      test_no_addr();
      test_back_to_back();
      test_suppress();
      test_log_en();
      test_overflow();
      test_reset_mid_send();
`ifdef SPI_LOG_TS_EN
      test_timestamp();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
